// File: rtl/spi_slave_sync.sv
// SPI slave oversampled in the CLK_50 domain: parametrised width/mode/sync depth,
// one-word TX holding buffer, RX valid/ready handshake with sticky overrun.
module spi_slave_sync #(
  parameter int WORD_W      = 16,
  parameter bit CPOL        = 1'b0,
  parameter bit CPHA        = 1'b0,
  parameter int SYNC_STAGES = 2
) (
  input  logic              CLK_50,
  input  logic              RST,
  input  logic              SCK,
  input  logic              MOSI,
  input  logic              CSbar,
  output logic              MISO,
  output logic              MISO_OE,
  input  logic [WORD_W-1:0] TX_DATA,
  input  logic              TX_VALID,
  output logic              TX_READY,
  output logic [WORD_W-1:0] RX_DATA,
  output logic              RX_VALID,
  input  logic              RX_READY,
  output logic              OVERRUN,
  input  logic              OVERRUN_CLR,
  output logic              BUSY,
  output logic              DBG_STATE
);

  localparam int CW = $clog2(WORD_W);
  localparam logic [CW-1:0] LAST_BIT = CW'(WORD_W - 1);

  typedef enum logic {ST_IDLE = 1'b0, ST_ACTIVE = 1'b1} state_t;

  // Handshakes: a TX word is taken on any cycle with TX_VALID & TX_READY;
  // an RX word is consumed on any cycle with RX_VALID & RX_READY.

  logic [SYNC_STAGES-1:0] r_sck_sync;
  logic [SYNC_STAGES-1:0] r_mosi_sync;
  logic [SYNC_STAGES-1:0] r_cs_sync;
  logic [SYNC_STAGES-1:0] r_warm;
  logic                   r_sck_d;
  logic                   r_armed;

  state_t            r_state;
  logic [CW-1:0]     r_bitcnt;
  logic [WORD_W-1:0] r_rx_sh;
  logic [WORD_W-1:0] r_tx_sh;
  logic [WORD_W-1:0] r_tx_buf;
  logic              r_tx_full;
  logic              r_miso;
  logic              r_miso_oe;
  logic              r_word_done;
  logic [WORD_W-1:0] r_rx_data;
  logic              r_rx_valid;
  logic              r_overrun;

  logic              w_sck_s;
  logic              w_mosi_s;
  logic              w_cs_s;
  logic              w_lead;
  logic              w_trail;
  logic              w_sample;
  logic              w_shift;
  logic              w_entry;
  logic              w_active;
  logic              w_load;
  logic              w_tx_accept;
  logic [WORD_W-1:0] w_load_word;
  logic [WORD_W-1:0] w_rx_next;

  assign w_sck_s  = r_sck_sync[SYNC_STAGES-1];
  assign w_mosi_s = r_mosi_sync[SYNC_STAGES-1];
  assign w_cs_s   = r_cs_sync[SYNC_STAGES-1];

  assign w_lead   = (r_sck_d == CPOL) && (w_sck_s != CPOL);
  assign w_trail  = (r_sck_d != CPOL) && (w_sck_s == CPOL);
  assign w_sample = CPHA ? w_trail : w_lead;
  assign w_shift  = CPHA ? w_lead : w_trail;

  // A frame may only start after CSbar has been seen high with the chain flushed,
  // so a reset in the middle of a frame waits for the next real CSbar fall.
  assign w_entry  = (r_state == ST_IDLE) && r_armed && !w_cs_s;
  assign w_active = (r_state == ST_ACTIVE) && !w_cs_s;
  assign w_load   = (w_entry && !CPHA) ||
                    (w_active && w_shift && (r_bitcnt == '0));

  assign w_load_word = r_tx_full ? r_tx_buf : '0;
  assign w_rx_next   = {r_rx_sh[WORD_W-2:0], w_mosi_s};
  assign w_tx_accept = TX_VALID && !r_tx_full;

  always_ff @(posedge CLK_50) begin
    if (RST) begin
      r_sck_sync  <= {SYNC_STAGES{CPOL}};
      r_mosi_sync <= '0;
      r_cs_sync   <= '1;
      r_warm      <= '0;
      r_sck_d     <= CPOL;
      r_armed     <= 1'b0;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], SCK};
      r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], MOSI};
      r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], CSbar};
      r_warm      <= {r_warm[SYNC_STAGES-2:0], 1'b1};
      r_sck_d     <= w_sck_s;
      if (r_warm[SYNC_STAGES-1] && w_cs_s) begin
        r_armed <= 1'b1;
      end
    end
  end

  always_ff @(posedge CLK_50) begin
    if (RST) begin
      r_state     <= ST_IDLE;
      r_bitcnt    <= '0;
      r_rx_sh     <= '0;
      r_tx_sh     <= '0;
      r_tx_buf    <= '0;
      r_tx_full   <= 1'b0;
      r_miso      <= 1'b0;
      r_miso_oe   <= 1'b0;
      r_word_done <= 1'b0;
      r_rx_data   <= '0;
      r_rx_valid  <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_word_done <= 1'b0;

      case (r_state)
        ST_IDLE: begin
          if (w_entry) begin
            r_state   <= ST_ACTIVE;
            r_miso_oe <= 1'b1;
            r_bitcnt  <= '0;
          end
        end
        ST_ACTIVE: begin
          // CSbar rising wins over any SCK strobe in the same cycle.
          if (w_cs_s) begin
            r_state   <= ST_IDLE;
            r_bitcnt  <= '0;
            r_rx_sh   <= '0;
            r_miso    <= 1'b0;
            r_miso_oe <= 1'b0;
          end else begin
            if (w_sample) begin
              r_rx_sh <= w_rx_next;
              if (r_bitcnt == LAST_BIT) begin
                r_bitcnt    <= '0;
                r_word_done <= 1'b1;
              end else begin
                r_bitcnt <= r_bitcnt + 1'b1;
              end
            end
            if (w_shift && !w_load) begin
              r_tx_sh <= r_tx_sh << 1;
              r_miso  <= r_tx_sh[WORD_W-2];
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase

      if (w_load) begin
        r_tx_sh   <= w_load_word;
        r_miso    <= w_load_word[WORD_W-1];
        r_tx_full <= 1'b0;
      end
      // No bypass: a word offered in the load cycle is held for the next word.
      if (w_tx_accept) begin
        r_tx_buf  <= TX_DATA;
        r_tx_full <= 1'b1;
      end

      if (RX_READY) begin
        r_rx_valid <= 1'b0;
      end
      if (OVERRUN_CLR) begin
        r_overrun <= 1'b0;
      end
      if (r_word_done) begin
        r_rx_data  <= r_rx_sh;
        r_rx_valid <= 1'b1;
        if (r_rx_valid && !RX_READY) begin
          r_overrun <= 1'b1;
        end
      end
    end
  end

  assign MISO      = r_miso;
  assign MISO_OE   = r_miso_oe;
  assign TX_READY  = !r_tx_full && !RST;
  assign RX_DATA   = r_rx_data;
  assign RX_VALID  = r_rx_valid;
  assign OVERRUN   = r_overrun;
  assign BUSY      = (r_state == ST_ACTIVE);
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_spi_slave_sync.sv
// Bench for spi_slave_sync: a mode-0 16-bit instance and a mode-3 8-bit instance,
// driven by a behavioural SPI master with a queue-based RX scoreboard.
module tb_spi_slave_sync;

  localparam int HALF = 5;

  logic clk = 1'b0;
  always #10 clk = ~clk;

  logic rst;
  logic sck0, mosi0, cs0, sck1, mosi1, cs1;
  logic miso0, oe0, tx_valid0, tx_ready0, rx_valid0, rx_ready0, overrun0, ovclr0, busy0, dbg0;
  logic miso1, oe1, tx_valid1, tx_ready1, rx_valid1, rx_ready1, overrun1, ovclr1, busy1, dbg1;
  logic [15:0] tx_data0, rx_data0;
  logic [7:0]  tx_data1, rx_data1;

  logic rx_auto0, rx_man0, auto_rdy0, auto_rdy1;
  assign rx_ready0 = rx_auto0 ? auto_rdy0 : rx_man0;
  assign rx_ready1 = auto_rdy1;

  spi_slave_sync #(.WORD_W(16), .CPOL(1'b0), .CPHA(1'b0), .SYNC_STAGES(2)) dut0 (
    .CLK_50(clk), .RST(rst), .SCK(sck0), .MOSI(mosi0), .CSbar(cs0),
    .MISO(miso0), .MISO_OE(oe0), .TX_DATA(tx_data0), .TX_VALID(tx_valid0),
    .TX_READY(tx_ready0), .RX_DATA(rx_data0), .RX_VALID(rx_valid0),
    .RX_READY(rx_ready0), .OVERRUN(overrun0), .OVERRUN_CLR(ovclr0),
    .BUSY(busy0), .DBG_STATE(dbg0)
  );

  spi_slave_sync #(.WORD_W(8), .CPOL(1'b1), .CPHA(1'b1), .SYNC_STAGES(2)) dut1 (
    .CLK_50(clk), .RST(rst), .SCK(sck1), .MOSI(mosi1), .CSbar(cs1),
    .MISO(miso1), .MISO_OE(oe1), .TX_DATA(tx_data1), .TX_VALID(tx_valid1),
    .TX_READY(tx_ready1), .RX_DATA(rx_data1), .RX_VALID(rx_valid1),
    .RX_READY(rx_ready1), .OVERRUN(overrun1), .OVERRUN_CLR(ovclr1),
    .BUSY(busy1), .DBG_STATE(dbg1)
  );

  int n_vec  = 0;
  int n_miss = 0;

  logic [15:0] exp_q0[$];
  logic [7:0]  exp_q1[$];

  // Master-side frame description shared by the transfer task.
  logic [15:0] m_mosi[4];
  bit          m_push_en[4];
  logic [15:0] m_push_w[4];
  logic [15:0] m_miso[4];
  bit          m_keep_cs;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  // RX scoreboard: each RX_VALID is compared against the queue head and acknowledged.
  always @(negedge clk) begin
    if (rx_valid0 && !rx_ready0 && rx_auto0) begin
      n_vec++;
      if (exp_q0.size() == 0) begin
        n_miss++;
        $display("FAIL rx0_unexpected: RX_VALID with data %h, no word expected", rx_data0);
      end else begin
        logic [15:0] e;
        e = exp_q0.pop_front();
        if (rx_data0 !== e) begin
          n_miss++;
          $display("FAIL rx0_data: got %h, expected %h", rx_data0, e);
        end
      end
      auto_rdy0 = 1'b1;
    end else begin
      auto_rdy0 = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rx_valid1 && !rx_ready1) begin
      n_vec++;
      if (exp_q1.size() == 0) begin
        n_miss++;
        $display("FAIL rx1_unexpected: RX_VALID with data %h, no word expected", rx_data1);
      end else begin
        logic [7:0] e;
        e = exp_q1.pop_front();
        if (rx_data1 !== e) begin
          n_miss++;
          $display("FAIL rx1_data: got %h, expected %h", rx_data1, e);
        end
      end
      auto_rdy1 = 1'b1;
    end else begin
      auto_rdy1 = 1'b0;
    end
  end

  task automatic set_sck(input int inst, input logic v);
    if (inst == 0) sck0 = v; else sck1 = v;
  endtask
  task automatic set_mosi(input int inst, input logic v);
    if (inst == 0) mosi0 = v; else mosi1 = v;
  endtask
  task automatic set_cs(input int inst, input logic v);
    if (inst == 0) cs0 = v; else cs1 = v;
  endtask

  task automatic push_tx(input int inst, input logic [15:0] d);
    int t;
    t = 0;
    while (((inst == 0) ? tx_ready0 : tx_ready1) !== 1'b1 && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (t >= 200) begin
      n_vec++;
      n_miss++;
      $display("FAIL tx_ready_timeout: inst %0d TX_READY never rose", inst);
    end
    if (inst == 0) begin
      tx_data0 = d; tx_valid0 = 1'b1;
    end else begin
      tx_data1 = d[7:0]; tx_valid1 = 1'b1;
    end
    @(negedge clk);
    tx_valid0 = 1'b0;
    tx_valid1 = 1'b0;
  endtask

  // Behavioural SPI master: instance 0 is mode 0 (16 bits), instance 1 is mode 3 (8 bits).
  task automatic spi_xfer(input int inst, input int nbits);
    int  w;
    logic idle_lvl;
    w        = (inst == 0) ? 16 : 8;
    idle_lvl = (inst == 0) ? 1'b0 : 1'b1;
    for (int j = 0; j < 4; j++) m_miso[j] = '0;
    set_cs(inst, 1'b0);
    repeat (6) @(negedge clk);
    for (int b = 0; b < nbits; b++) begin
      int k, i;
      k = b / w;
      i = w - 1 - (b % w);
      if ((b % w) == 4 && m_push_en[k]) push_tx(inst, m_push_w[k]);
      set_mosi(inst, m_mosi[k][i]);
      if (inst == 0) begin
        repeat (HALF) @(negedge clk);
        m_miso[k][i] = miso0;
        set_sck(inst, ~idle_lvl);
        repeat (HALF) @(negedge clk);
        set_sck(inst, idle_lvl);
      end else begin
        set_sck(inst, ~idle_lvl);
        repeat (HALF) @(negedge clk);
        m_miso[k][i] = miso1;
        set_sck(inst, idle_lvl);
        repeat (HALF) @(negedge clk);
      end
    end
    if (!m_keep_cs) begin
      repeat (HALF) @(negedge clk);
      set_cs(inst, 1'b1);
      repeat (10) @(negedge clk);
    end
  endtask

  task automatic clear_frame();
    for (int j = 0; j < 4; j++) begin
      m_mosi[j] = '0; m_push_en[j] = 1'b0; m_push_w[j] = '0;
    end
    m_keep_cs = 1'b0;
  endtask

  typedef struct {
    bit          pre;
    logic [15:0] tx;
    logic [15:0] mosi;
    logic [15:0] exp_rx;
    logic [15:0] exp_miso;
  } vec_t;

  vec_t vt[5];

  initial begin
    #1_500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] exp_w[4];
    bit          mfull;
    logic [15:0] mbuf;
    int          n;
    bit          pre;
    logic [15:0] pre_w;

    rst = 1'b1;
    sck0 = 1'b0; mosi0 = 1'b0; cs0 = 1'b1;
    sck1 = 1'b1; mosi1 = 1'b0; cs1 = 1'b1;
    tx_data0 = '0; tx_valid0 = 1'b0; tx_data1 = '0; tx_valid1 = 1'b0;
    rx_auto0 = 1'b1; rx_man0 = 1'b0; ovclr0 = 1'b0; ovclr1 = 1'b0;
    clear_frame();

    vt[0] = '{1'b1, 16'hA5C3, 16'h1234, 16'h1234, 16'hA5C3};
    vt[1] = '{1'b0, 16'hFFFF, 16'hC001, 16'hC001, 16'h0000};
    vt[2] = '{1'b1, 16'hFFFF, 16'h0000, 16'h0000, 16'hFFFF};
    vt[3] = '{1'b1, 16'h8001, 16'h7FFE, 16'h7FFE, 16'h8001};
    vt[4] = '{1'b1, 16'h0001, 16'h8000, 16'h8000, 16'h0001};

    repeat (3) @(negedge clk);
    check("rst_miso", miso0, 0);
    check("rst_miso_oe", oe0, 0);
    check("rst_tx_ready", tx_ready0, 0);
    check("rst_rx_data", rx_data0, 0);
    check("rst_rx_valid", rx_valid0, 0);
    check("rst_overrun", overrun0, 0);
    check("rst_busy", busy0, 0);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("tx_ready_after_rst0", tx_ready0, 1);
    check("tx_ready_after_rst1", tx_ready1, 1);

    // Single-word mode-0 frames from the table.
    for (int v = 0; v < 5; v++) begin
      clear_frame();
      if (vt[v].pre) push_tx(0, vt[v].tx);
      m_mosi[0] = vt[v].mosi;
      exp_q0.push_back(vt[v].exp_rx);
      spi_xfer(0, 16);
      check($sformatf("vec%0d_miso", v), m_miso[0], vt[v].exp_miso);
      check($sformatf("vec%0d_tx_ready", v), tx_ready0, 1);
      check($sformatf("vec%0d_oe_idle", v), oe0, 0);
    end

    // Two words in one frame, second TX word supplied mid-word.
    clear_frame();
    push_tx(0, 16'h1111);
    m_push_en[0] = 1'b1; m_push_w[0] = 16'h2222;
    m_mosi[0] = 16'hBEEF; m_mosi[1] = 16'h0F0F;
    exp_q0.push_back(16'hBEEF);
    exp_q0.push_back(16'h0F0F);
    spi_xfer(0, 32);
    check("two_word_miso0", m_miso[0], 16'h1111);
    check("two_word_miso1", m_miso[1], 16'h2222);

    // Random multi-word frames against a one-word buffer model.
    mfull = 1'b0;
    mbuf  = '0;
    for (int f = 0; f < 12; f++) begin
      clear_frame();
      n = $urandom_range(1, 3);
      pre = ($urandom_range(0, 1) == 1) && !mfull;
      pre_w = 16'($urandom);
      for (int k = 0; k < n; k++) begin
        m_mosi[k]    = 16'($urandom);
        m_push_en[k] = ($urandom_range(0, 1) == 1);
        m_push_w[k]  = 16'($urandom);
        exp_q0.push_back(m_mosi[k]);
      end
      if (pre) begin
        mbuf = pre_w; mfull = 1'b1;
      end
      exp_w[0] = mfull ? mbuf : 16'h0000;
      mfull = 1'b0;
      for (int k = 0; k < n; k++) begin
        if (m_push_en[k]) begin
          mbuf = m_push_w[k]; mfull = 1'b1;
        end
        if (k + 1 < n) exp_w[k+1] = mfull ? mbuf : 16'h0000;
        mfull = 1'b0;
      end
      if (pre) push_tx(0, pre_w);
      spi_xfer(0, n * 16);
      for (int k = 0; k < n; k++) begin
        check($sformatf("rand%0d_w%0d_miso", f, k), m_miso[k], exp_w[k]);
      end
    end

    // Overrun: two words with RX_READY held low.
    clear_frame();
    rx_auto0 = 1'b0;
    m_mosi[0] = 16'hABCD; m_mosi[1] = 16'h1357;
    spi_xfer(0, 32);
    check("ovr_rx_valid", rx_valid0, 1);
    check("ovr_rx_data", rx_data0, 16'h1357);
    check("ovr_flag", overrun0, 1);

    // Reset in the middle of a frame.
    clear_frame();
    push_tx(0, 16'h5555);
    m_mosi[0] = 16'hFFFF;
    m_keep_cs = 1'b1;
    spi_xfer(0, 5);
    check("mid_busy", busy0, 1);
    check("mid_oe", oe0, 1);
    rst = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("mrst_miso", miso0, 0);
    check("mrst_oe", oe0, 0);
    check("mrst_tx_ready", tx_ready0, 0);
    check("mrst_rx_valid", rx_valid0, 0);
    check("mrst_rx_data", rx_data0, 0);
    check("mrst_overrun", overrun0, 0);
    check("mrst_busy", busy0, 0);
    rst = 1'b0;
    rx_auto0 = 1'b1;
    repeat (10) @(negedge clk);
    check("mrst_stays_idle", busy0, 0);
    check("mrst_buf_cleared", tx_ready0, 1);
    sck0 = 1'b0;
    m_keep_cs = 1'b0;
    spi_xfer(0, 16);
    check("mrst_no_drive", m_miso[0], 16'h0000);

    // Overrun clear.
    clear_frame();
    rx_auto0 = 1'b0;
    m_mosi[0] = 16'h2468; m_mosi[1] = 16'h9BDF;
    spi_xfer(0, 32);
    check("ovr2_flag", overrun0, 1);
    check("ovr2_rx_data", rx_data0, 16'h9BDF);
    ovclr0 = 1'b1;
    @(negedge clk);
    ovclr0 = 1'b0;
    @(negedge clk);
    check("ovr_clr", overrun0, 0);
    rx_man0 = 1'b1;
    @(negedge clk);
    rx_man0 = 1'b0;
    @(negedge clk);
    check("rx_ready_clears", rx_valid0, 0);
    rx_auto0 = 1'b1;

    // Partial word then full frame; buffered word offered mid-partial survives.
    clear_frame();
    m_mosi[0] = 16'hFFFF;
    m_push_en[0] = 1'b1; m_push_w[0] = 16'h5A5A;
    spi_xfer(0, 7);
    check("partial_oe", oe0, 0);
    check("partial_miso", miso0, 0);
    check("partial_buf_kept", tx_ready0, 0);
    clear_frame();
    m_mosi[0] = 16'h00FF;
    exp_q0.push_back(16'h00FF);
    spi_xfer(0, 16);
    check("after_partial_miso", m_miso[0], 16'h5A5A);
    check("after_partial_rx", rx_data0, 16'h00FF);

    // Mode 3, 8-bit instance.
    clear_frame();
    push_tx(1, 16'h003C);
    m_mosi[0] = 16'h0081;
    exp_q1.push_back(8'h81);
    spi_xfer(1, 8);
    check("m3_miso", m_miso[0][7:0], 8'h3C);
    check("m3_rx_data", rx_data1, 8'h81);

    clear_frame();
    m_mosi[0] = 16'h005A;
    exp_q1.push_back(8'h5A);
    spi_xfer(1, 8);
    check("m3_empty_miso", m_miso[0][7:0], 8'h00);

    clear_frame();
    push_tx(1, 16'h00C3);
    m_push_en[0] = 1'b1; m_push_w[0] = 16'h0096;
    m_mosi[0] = 16'h0001; m_mosi[1] = 16'h00FE;
    exp_q1.push_back(8'h01);
    exp_q1.push_back(8'hFE);
    spi_xfer(1, 16);
    check("m3_two_miso0", m_miso[0][7:0], 8'hC3);
    check("m3_two_miso1", m_miso[1][7:0], 8'h96);

    repeat (20) @(negedge clk);
    check("rx0_queue_drained", exp_q0.size(), 0);
    check("rx1_queue_drained", exp_q1.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
